// File: rtl/core_pkg.sv
// Shared widths, opcodes and EX-stage FSM states for the 8-bit pipelined core.
package core_pkg;
   localparam int DATA_W  = 8;
   localparam int RADDR_W = 3;
   localparam int IMM_W   = 3;
   localparam int ADDR_W  = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LI  = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_J   = 2'b11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } ex_state_t;
endpackage

// File: rtl/forward_mux.sv
// Operand forward select: own output register beats writeback beats register file.
// Purely combinational; no flow control.
module forward_mux #(
   parameter int DATA_W  = 8,
   parameter int RADDR_W = 3
) (
   input  logic [RADDR_W-1:0] index,
   input  logic [DATA_W-1:0]  rf_data,
   input  logic               out_valid,
   input  logic               out_we,
   input  logic [RADDR_W-1:0] out_rdest,
   input  logic [DATA_W-1:0]  out_data,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_rdest,
   input  logic [DATA_W-1:0]  wb_data,
   output logic [DATA_W-1:0]  operand
);
   always_comb begin
      operand = rf_data;
      if (out_valid && out_we && (out_rdest == index)) begin
         operand = out_data;
      end else if (wb_we && (wb_rdest == index)) begin
         operand = wb_data;
      end
   end
endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarded ALU with a registered result and a jump redirect/squash FSM.
// Latency 1 cycle; no backpressure, one slot accepted every cycle.
module execute_stage
   import core_pkg::*;
#(
   parameter int DATA_W       = core_pkg::DATA_W,
   parameter int RADDR_W      = core_pkg::RADDR_W,
   parameter int IMM_W        = core_pkg::IMM_W,
   parameter int ADDR_W       = core_pkg::ADDR_W,
   parameter int SQUASH_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [1:0]         in_opcode,
   input  logic [RADDR_W-1:0] in_rdest,
   input  logic [RADDR_W-1:0] in_rsrc,
   input  logic [IMM_W-1:0]   in_imm,
   input  logic [ADDR_W-1:0]  in_jump_addr,
   input  logic [DATA_W-1:0]  in_rd_data,
   input  logic [DATA_W-1:0]  in_rs_data,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_rdest,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               out_valid,
   output logic               out_we,
   output logic [1:0]         out_opcode,
   output logic [RADDR_W-1:0] out_rdest,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_carry,
   output logic               redirect_valid,
   output logic [ADDR_W-1:0]  redirect_addr,
   output logic               squashing
);
   localparam int CNT_W = $clog2(SQUASH_DEPTH + 1);

   ex_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             eff_valid;
   logic             take_jump;
   logic [DATA_W-1:0] rd_op, rs_op;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_data;
   logic              alu_carry;

   assign eff_valid = in_valid && (state == ST_RUN);
   assign take_jump = eff_valid && (in_opcode == OP_J);
   assign squashing = (state == ST_SQUASH);

   forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rd (
      .index(in_rdest), .rf_data(in_rd_data),
      .out_valid(out_valid), .out_we(out_we), .out_rdest(out_rdest), .out_data(out_data),
      .wb_we(wb_we), .wb_rdest(wb_rdest), .wb_data(wb_data),
      .operand(rd_op)
   );

   forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
      .index(in_rsrc), .rf_data(in_rs_data),
      .out_valid(out_valid), .out_we(out_we), .out_rdest(out_rdest), .out_data(out_data),
      .wb_we(wb_we), .wb_rdest(wb_rdest), .wb_data(wb_data),
      .operand(rs_op)
   );

   assign sum = {1'b0, rd_op} + {1'b0, rs_op};

   // LI and J leave the carry flag untouched
   always_comb begin
      alu_data  = '0;
      alu_carry = out_carry;
      case (in_opcode)
         OP_ADD: begin
            alu_data  = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
         end
         OP_SUB: begin
            alu_data  = rd_op - rs_op;
            alu_carry = (rd_op < rs_op);
         end
         OP_LI:   alu_data = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
         OP_J:    alu_data = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (take_jump) begin
               state_nxt = ST_SQUASH;
               cnt_nxt   = CNT_W'(SQUASH_DEPTH);
            end
         end
         ST_SQUASH: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_RUN;
         cnt            <= '0;
         out_valid      <= 1'b0;
         out_we         <= 1'b0;
         out_opcode     <= '0;
         out_rdest      <= '0;
         out_data       <= '0;
         out_carry      <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_addr  <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         out_valid      <= eff_valid;
         out_we         <= eff_valid && (in_opcode != OP_J);
         redirect_valid <= take_jump;
         if (take_jump) begin
            redirect_addr <= in_jump_addr;
         end
         if (eff_valid) begin
            out_opcode <= in_opcode;
            out_rdest  <= in_rdest;
            out_data   <= alu_data;
            out_carry  <= alu_carry;
         end
      end
   end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, then random traffic against a slot-level model.
module tb_execute_stage;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [1:0] in_opcode;
   logic [2:0] in_rdest, in_rsrc, in_imm;
   logic [7:0] in_jump_addr, in_rd_data, in_rs_data;
   logic       wb_we;
   logic [2:0] wb_rdest;
   logic [7:0] wb_data;
   logic       out_valid, out_we, out_carry, redirect_valid, squashing;
   logic [1:0] out_opcode;
   logic [2:0] out_rdest;
   logic [7:0] out_data, redirect_addr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_imm(in_imm), .in_jump_addr(in_jump_addr),
      .in_rd_data(in_rd_data), .in_rs_data(in_rs_data),
      .wb_we(wb_we), .wb_rdest(wb_rdest), .wb_data(wb_data),
      .out_valid(out_valid), .out_we(out_we), .out_opcode(out_opcode), .out_rdest(out_rdest),
      .out_data(out_data), .out_carry(out_carry),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .squashing(squashing)
   );

   typedef struct {
      logic       rst, iv;
      logic [1:0] op;
      logic [2:0] rd, rs, imm;
      logic [7:0] ja, rdd, rsd;
      logic       wbwe;
      logic [2:0] wbrd;
      logic [7:0] wbd;
      logic       ev, ewe;
      logic [7:0] edat;
      logic       ec, er;
      logic [7:0] era;
      logic       esq;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic rst, logic iv, logic [1:0] op, logic [2:0] rd, logic [2:0] rs,
                               logic [2:0] imm, logic [7:0] ja, logic [7:0] rdd, logic [7:0] rsd,
                               logic wbwe, logic [2:0] wbrd, logic [7:0] wbd,
                               logic ev, logic ewe, logic [7:0] edat, logic ec, logic er,
                               logic [7:0] era, logic esq);
      vec_t v;
      v.rst = rst; v.iv = iv; v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.ja = ja;
      v.rdd = rdd; v.rsd = rsd; v.wbwe = wbwe; v.wbrd = wbrd; v.wbd = wbd;
      v.ev = ev; v.ewe = ewe; v.edat = edat; v.ec = ec; v.er = er; v.era = era; v.esq = esq;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(logic rst, logic iv, logic [1:0] op, logic [2:0] rd, logic [2:0] rs,
                        logic [2:0] imm, logic [7:0] ja, logic [7:0] rdd, logic [7:0] rsd,
                        logic wbwe, logic [2:0] wbrd, logic [7:0] wbd);
      reset = rst; in_valid = iv; in_opcode = op; in_rdest = rd; in_rsrc = rs; in_imm = imm;
      in_jump_addr = ja; in_rd_data = rdd; in_rs_data = rsd;
      wb_we = wbwe; wb_rdest = wbrd; wb_data = wbd;
   endtask

   // Slot-level reference: expected architectural outputs plus a count of slots still to kill.
   logic       m_valid, m_we, m_carry, m_redir;
   logic [1:0] m_opcode;
   logic [2:0] m_rdest;
   logic [7:0] m_data, m_raddr;
   int         kill;

   function automatic logic [7:0] fwd(logic [2:0] idx, logic [7:0] rf);
      if (m_valid && m_we && m_rdest == idx) return m_data;
      if (wb_we && wb_rdest == idx) return wb_data;
      return rf;
   endfunction

   task automatic model_step();
      logic [7:0] a, b;
      int s, v;
      if (reset) begin
         m_valid = 0; m_we = 0; m_carry = 0; m_redir = 0; m_opcode = 0; m_rdest = 0;
         m_data = 0; m_raddr = 0; kill = 0;
         return;
      end
      a = fwd(in_rdest, in_rd_data);
      b = fwd(in_rsrc, in_rs_data);
      m_redir = 0;
      if (in_valid && kill == 0) begin
         m_valid = 1; m_we = (in_opcode != 2'b11); m_opcode = in_opcode; m_rdest = in_rdest;
         case (in_opcode)
            2'b00: begin s = int'(a) + int'(b); m_data = 8'(s % 256); m_carry = (s > 255); end
            2'b10: begin s = int'(a) - int'(b); m_data = 8'((s + 256) % 256); m_carry = (a < b); end
            2'b01: begin v = int'(in_imm); if (v >= 4) v -= 8; m_data = 8'(v & 255); end
            default: begin m_data = 0; m_redir = 1; m_raddr = in_jump_addr; kill = 3; end
         endcase
      end else begin
         m_valid = 0; m_we = 0;
      end
      if (kill > 0) kill--;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // kill is preloaded to depth+1 and decremented on the same step, leaving two squashed slots
      vt.push_back(mk(1,0,2'd0,0,0,0,8'h00,8'h00,8'h00,0,0,8'h00, 0,0,8'h00,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd1,1,0,3,8'h00,8'h00,8'h00,0,0,8'h00, 1,1,8'h03,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd0,1,1,0,8'h00,8'h00,8'h00,0,0,8'h00, 1,1,8'h06,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd0,2,3,0,8'h00,8'hF0,8'h20,0,0,8'h00, 1,1,8'h10,1,0,8'h00,0));
      vt.push_back(mk(0,1,2'd2,3,4,0,8'h00,8'h05,8'h07,0,0,8'h00, 1,1,8'hFE,1,0,8'h00,0));
      vt.push_back(mk(0,1,2'd0,4,0,0,8'h00,8'h11,8'h00,0,0,8'h00, 1,1,8'h11,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd0,5,4,0,8'h00,8'h01,8'h55,1,4,8'h22, 1,1,8'h12,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd3,0,0,0,8'h40,8'h00,8'h00,0,0,8'h00, 1,0,8'h00,0,1,8'h40,1));
      vt.push_back(mk(0,1,2'd0,1,2,0,8'h00,8'h01,8'h01,0,0,8'h00, 0,0,8'h00,0,0,8'h40,1));
      vt.push_back(mk(0,1,2'd3,0,0,0,8'h80,8'h00,8'h00,0,0,8'h00, 0,0,8'h00,0,0,8'h40,0));
      vt.push_back(mk(0,1,2'd0,6,7,0,8'h00,8'h03,8'h04,0,0,8'h00, 1,1,8'h07,0,0,8'h40,0));
      vt.push_back(mk(0,1,2'd1,6,0,4,8'h00,8'h00,8'h00,0,0,8'h00, 1,1,8'hFC,0,0,8'h40,0));
      vt.push_back(mk(0,0,2'd0,6,0,0,8'h00,8'h00,8'h00,0,0,8'h00, 0,0,8'hFC,0,0,8'h40,0));
      vt.push_back(mk(0,1,2'd3,0,0,0,8'h22,8'h00,8'h00,0,0,8'h00, 1,0,8'h00,0,1,8'h22,1));
      vt.push_back(mk(0,0,2'd0,0,0,0,8'h00,8'h00,8'h00,0,0,8'h00, 0,0,8'h00,0,0,8'h22,1));
      vt.push_back(mk(1,1,2'd3,0,0,0,8'h99,8'h00,8'h00,0,0,8'h00, 0,0,8'h00,0,0,8'h00,0));
      vt.push_back(mk(0,1,2'd0,1,2,0,8'h00,8'hFF,8'h01,0,0,8'h00, 1,1,8'h00,1,0,8'h00,0));
      vt.push_back(mk(0,1,2'd1,2,0,1,8'h00,8'h00,8'h00,0,0,8'h00, 1,1,8'h01,1,0,8'h00,0));

      @(posedge clk); #1;
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].rst, vt[i].iv, vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm, vt[i].ja,
               vt[i].rdd, vt[i].rsd, vt[i].wbwe, vt[i].wbrd, vt[i].wbd);
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
         chk($sformatf("v%0d out_we", i), 32'(out_we), 32'(vt[i].ewe));
         chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].edat));
         chk($sformatf("v%0d out_carry", i), 32'(out_carry), 32'(vt[i].ec));
         chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vt[i].er));
         chk($sformatf("v%0d redirect_addr", i), 32'(redirect_addr), 32'(vt[i].era));
         chk($sformatf("v%0d squashing", i), 32'(squashing), 32'(vt[i].esq));
      end

      // Hand sequence: three chained ADDs into r7 with a stale regfile, no bubbles.
      drive(0, 1, 2'd1, 7, 0, 3'd1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("chain li", 32'(out_data), 32'h01);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 2'd0, 7, 7, 0, 0, 8'h00, 8'h00, 1, 7, 8'hAA);
         @(posedge clk); #1;
         chk($sformatf("chain add%0d", k), 32'(out_data), 32'(8'h01 << (k + 1)));
      end

      // Random traffic with occasional resets.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_step();
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 3'($urandom_range(0, 3)), 8'($urandom));
         model_step();
         @(posedge clk); #1;
         chk("rand out_valid", 32'(out_valid), 32'(m_valid));
         chk("rand out_we", 32'(out_we), 32'(m_we));
         chk("rand out_opcode", 32'(out_opcode), 32'(m_opcode));
         chk("rand out_rdest", 32'(out_rdest), 32'(m_rdest));
         chk("rand out_data", 32'(out_data), 32'(m_data));
         chk("rand out_carry", 32'(out_carry), 32'(m_carry));
         chk("rand redirect_valid", 32'(redirect_valid), 32'(m_redir));
         chk("rand redirect_addr", 32'(redirect_addr), 32'(m_raddr));
         chk("rand squashing", 32'(squashing), 32'(kill > 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 8-bit pipelined core. It sits between the ID/EX pipeline register and the EX/WB pipeline register.
- Consumes the decoded opcode, register indices, immediate, jump address and register-file operands. Produces the registered ALU result that the EX/WB register latches as alu_data.
- Contains result forwarding from its own output and from writeback.
- Contains the jump-redirect / squash state machine that kills the younger in-flight instructions after a taken jump.

Parameters:
- DATA_W, 8, operand/result width
- RADDR_W, 3, register index width
- IMM_W, 3, immediate width (two's complement)
- ADDR_W, 8, instruction address width
- SQUASH_DEPTH, 2, cycles of younger instructions killed after a jump

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  ID/EX slot holds a real instruction
- in_opcode  in  2  00 ADD, 01 LI, 10 SUB, 11 J
- in_rdest  in  RADDR_W  destination / first operand index
- in_rsrc  in  RADDR_W  source operand index
- in_imm  in  IMM_W  signed immediate
- in_jump_addr  in  ADDR_W  jump target
- in_rd_data  in  DATA_W  register-file value of in_rdest
- in_rs_data  in  DATA_W  register-file value of in_rsrc
- wb_we  in  1  writeback stage is writing this cycle
- wb_rdest  in  RADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  registered result valid
- out_we  out  1  result must be written to register file
- out_opcode  out  2  opcode of the retired slot
- out_rdest  out  RADDR_W  destination of result
- out_data  out  DATA_W  ALU result (alu_data)
- out_carry  out  1  carry/borrow of last ADD/SUB
- redirect_valid  out  1  one-cycle pulse: PC must load redirect_addr
- redirect_addr  out  ADDR_W  jump target
- squashing  out  1  high while younger slots are being killed

Behaviour:
- Reset:
  - All outputs 0.
  - FSM enters RUN; squash counter 0.
  - The reset clear takes priority over every other event in that cycle, including mid-squash and mid-jump.
- Effective valid: eff_valid = in_valid && state==RUN.
- Operand forwarding, applied per operand (rd and rs independently), in priority order:
  1. out_valid && out_we && out_rdest==index: use out_data (the older instruction still in this stage's output register).
  2. Otherwise wb_we && wb_rdest==index: use wb_data.
  3. Otherwise use the register-file value.
- ALU, all results truncated to DATA_W; latency 1 cycle (registered at clk edge):
  - ADD: out_data = rd + rs; out_carry = bit DATA_W of the sum.
  - SUB: out_data = rd - rs; out_carry = borrow (rd < rs, unsigned).
  - LI: out_data = in_imm sign-extended to DATA_W, so 3'b111 gives 8'hFF. out_carry holds its previous value.
  - J: out_data = 0 and out_we = 0. out_carry holds its previous value.
- Output register:
  - Every cycle, out_valid <= eff_valid.
  - out_we <= eff_valid && opcode != J.
  - When !eff_valid, out_we = 0 and out_data/out_rdest/out_opcode hold their previous values.
- Jump FSM, states RUN and SQUASH:
  - RUN with eff_valid && J:
    - Next cycle: redirect_valid=1 for exactly one cycle and redirect_addr = in_jump_addr.
    - State goes to SQUASH with counter = SQUASH_DEPTH.
  - SQUASH:
    - squashing=1.
    - Counter decrements every cycle regardless of in_valid.
    - When the counter reaches 1, the next state is RUN.
    - Any instruction presented in SQUASH, including a J, is discarded: no result, no redirect.
  - A jump as the last instruction before reset is dropped; reset wins.
- Back-to-back ADDs to the same register chain through forwarding with no bubble.
- No stall input: the stage accepts one slot per cycle.

Decomposition:
- Shared package core_pkg:
  - Opcode constants OP_ADD=2'b00, OP_LI=2'b01, OP_SUB=2'b10, OP_J=2'b11.
  - Width constants DATA_W/RADDR_W/IMM_W/ADDR_W.
  - FSM state enum.
- One sub-module, forward_mux: one instance per operand. It encodes the three-way priority select so both operands use identical logic.
- ALU and FSM stay in execute_stage.

Test Plan:
- Reset forced mid-SQUASH (counter=1) -> next cycle all outputs 0, state RUN, squashing=0; the instruction presented after reset executes normally.
- LI r1,3 then ADD r1,r1 with stale regfile r1=0 -> out_data 8'h03, then 8'h06 via self-forward; out_we=1 both cycles.
- ADD r2,r3 with in_rd_data=8'hF0, in_rs_data=8'h20 -> out_data=8'h10, out_carry=1. Then SUB 8'h05-8'h07 -> 8'hFE, out_carry=1.
- Forward priority: out reg r4=8'h11 and wb writing r4=8'h22 simultaneously, then ADD r5,r4 with in_rd_data=8'h01 -> result 8'h12 (own output wins).
- J 8'h40 followed by valid ADD, J 8'h80, ADD, ADD -> one redirect pulse with addr 8'h40; the next two slots (ADD, J 8'h80) are dropped with out_valid=0 and no second redirect; the third slot (ADD) executes.
- LI r6,imm=3'b100 -> out_data=8'hFC; a cycle with in_valid=0 -> out_valid=0, out_we=0, out_data still 8'hFC.
